grid_image_render: RTL

GRID_IMAGE_RENDER -- requirements
Module: grid_image_render

---
 rtl/grid_render_pkg.sv | 29 ++
 rtl/pix_delay_line.sv | 25 ++
 rtl/grid_image_render.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/grid_render_pkg.sv
// Shared state encoding, colours and header addresses for the grid image renderer.
package grid_render_pkg;

   typedef enum logic [2:0] {
      RD_WH,
      RD_WL,
      RD_HH,
      RD_HL,
      CALC,
      DISPLAY,
      HDR_ERR
   } state_t;

   localparam logic [23:0] DEF_LINE_COLOR = 24'hFF0000;
   localparam logic [23:0] DEF_FILL_COLOR = 24'hFFFFFF;
   localparam logic [23:0] HL_COLOR       = 24'h00FF00;

   localparam logic [17:0] ADDR_WH = 18'd0;
   localparam logic [17:0] ADDR_WL = 18'd1;
   localparam logic [17:0] ADDR_HH = 18'd4;
   localparam logic [17:0] ADDR_HL = 18'd5;

   // True when pos lies in [base, base + thick).
   function automatic logic in_band(input logic [16:0] pos, input logic [16:0] base,
                                    input logic [16:0] thick);
      return (pos >= base) && (pos < base + thick);
   endfunction

endpackage

// File: rtl/pix_delay_line.sv
// Fixed-depth shift register that keeps pixel coordinates aligned with RAM read data.
module pix_delay_line #(
   parameter int unsigned Depth = 2,
   parameter int unsigned Width = 21
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [Width-1:0] din,
   output logic [Width-1:0] dout
);

   logic [Width-1:0] stage_q [Depth];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(Depth); i++) stage_q[i] <= '0;
      end else begin
         stage_q[0] <= din;
         for (int i = 1; i < int'(Depth); i++) stage_q[i] <= stage_q[i-1];
      end
   end

   assign dout = stage_q[Depth-1];

endmodule

// File: rtl/grid_image_render.sv
// Reads a width/height header from RAM, then renders grey pixels with a DIVS x DIVS grid.
// Define GRID_HIGHLIGHT_EN to outline the cell chosen by sel in green.
module grid_image_render
   import grid_render_pkg::*;
#(
   parameter int unsigned HRES       = 640,
   parameter int unsigned VRES       = 480,
   parameter int unsigned DIVS       = 4,
   parameter int unsigned LINE_W     = 1,
   parameter logic [17:0] BASE_ADDR  = 18'h10,
   parameter int unsigned RD_LAT     = 2,
   parameter logic [23:0] LINE_COLOR = DEF_LINE_COLOR,
   parameter logic [23:0] FILL_COLOR = DEF_FILL_COLOR
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [9:0]  x,
   input  logic [9:0]  y,
   input  logic [7:0]  sel,
   input  logic [7:0]  q,
   output logic [17:0] rdaddress,
   output logic [7:0]  red,
   output logic [7:0]  green,
   output logic [7:0]  blue,
   output logic        hdr_ok
);

   localparam int unsigned LOG2_DIVS = $clog2(DIVS);
   localparam logic [2:0]  LAST_CNT  = 3'(RD_LAT);
   localparam logic [16:0] LW        = 17'(LINE_W);

   state_t      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [15:0] width_q, height_q;
   logic [17:0] addr_hold_q, row_off, pix_addr;
   logic        rd_state, rd_last, hdr_bad, in_img;
   logic [9:0]  d_x, d_y;
   logic        d_flag;
   logic [16:0] pos_x, pos_y, cell_w, cell_h;
   logic        on_line, on_hl;
   logic [23:0] rgb_d, rgb_q;

   assign rd_state = state_q inside {RD_WH, RD_WL, RD_HH, RD_HL};
   assign rd_last  = (cnt_q == LAST_CNT);
   assign hdr_bad  = (width_q == '0) || (height_q == '0) ||
                     (width_q > 16'(HRES)) || (height_q > 16'(VRES));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RD_WH;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = (rd_state && !rd_last) ? cnt_q + 3'd1 : 3'd0;
      unique case (state_q)
         RD_WH:   if (rd_last) state_d = RD_WL;
         RD_WL:   if (rd_last) state_d = RD_HH;
         RD_HH:   if (rd_last) state_d = RD_HL;
         RD_HL:   if (rd_last) state_d = CALC;
         CALC:    state_d = hdr_bad ? HDR_ERR : DISPLAY;
         DISPLAY: state_d = DISPLAY;
         HDR_ERR: state_d = HDR_ERR;
         default: state_d = RD_WH;
      endcase
   end

   // Header bytes land directly in the big-endian width/height registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         width_q  <= '0;
         height_q <= '0;
      end else if (rd_last) begin
         case (state_q)
            RD_WH:   width_q[15:8]  <= q;
            RD_WL:   width_q[7:0]   <= q;
            RD_HH:   height_q[15:8] <= q;
            RD_HL:   height_q[7:0]  <= q;
            default: ;
         endcase
      end
   end

   assign in_img   = ({6'd0, x} < width_q) && ({6'd0, y} < height_q);
   assign row_off  = {8'd0, y} * {2'd0, width_q};
   assign pix_addr = BASE_ADDR + row_off + {8'd0, x};

   always_comb begin
      rdaddress = addr_hold_q;
      hdr_ok    = 1'b0;
      unique case (state_q)
         RD_WH:   rdaddress = ADDR_WH;
         RD_WL:   rdaddress = ADDR_WL;
         RD_HH:   rdaddress = ADDR_HH;
         RD_HL:   rdaddress = ADDR_HL;
         DISPLAY: begin
            hdr_ok = 1'b1;
            if (in_img) rdaddress = pix_addr;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) addr_hold_q <= '0;
      else     addr_hold_q <= rdaddress;
   end

   pix_delay_line #(
      .Depth (RD_LAT),
      .Width (21)
   ) u_delay (
      .clk  (clk),
      .rst  (rst),
      .din  ({(state_q == DISPLAY) && in_img, y, x}),
      .dout ({d_flag, d_y, d_x})
   );

   assign pos_x  = {7'd0, d_x};
   assign pos_y  = {7'd0, d_y};
   assign cell_w = {1'b0, width_q >> LOG2_DIVS};
   assign cell_h = {1'b0, height_q >> LOG2_DIVS};

   always_comb begin
      on_line = 1'b0;
      for (int k = 1; k < int'(DIVS); k++) begin
         if (in_band(pos_x, 17'(k) * cell_w, LW) || in_band(pos_y, 17'(k) * cell_h, LW)) begin
            on_line = 1'b1;
         end
      end
   end

`ifdef GRID_HIGHLIGHT_EN
   logic [16:0] hl_x0, hl_y0;
   logic        hl_in_cell, hl_edge;

   always_comb begin
      hl_x0      = 17'(sel & 8'(DIVS - 1)) * cell_w;
      hl_y0      = 17'(sel >> LOG2_DIVS) * cell_h;
      hl_in_cell = (pos_x >= hl_x0) && (pos_x < hl_x0 + cell_w) &&
                   (pos_y >= hl_y0) && (pos_y < hl_y0 + cell_h);
      hl_edge    = in_band(pos_x, hl_x0, LW) || (pos_x + LW >= hl_x0 + cell_w) ||
                   in_band(pos_y, hl_y0, LW) || (pos_y + LW >= hl_y0 + cell_h);
      on_hl      = ({24'd0, sel} < 32'(DIVS * DIVS)) && hl_in_cell && hl_edge;
   end
`else
   logic sel_unused;
   assign sel_unused = ^sel;
   assign on_hl      = 1'b0;
`endif

   always_comb begin
      rgb_d = 24'h0;
      if (state_q == HDR_ERR) begin
         rgb_d = FILL_COLOR;
      end else if (state_q == DISPLAY) begin
         if (!d_flag)      rgb_d = FILL_COLOR;
         else if (on_hl)   rgb_d = HL_COLOR;
         else if (on_line) rgb_d = LINE_COLOR;
         else              rgb_d = {q, q, q};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) rgb_q <= '0;
      else     rgb_q <= rgb_d;
   end

   assign {red, green, blue} = rgb_q;

endmodule
